// File: rtl/vga_pkg.sv
// Shared VGA timing types and standard mode constants for raster generator sites.
package vga_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } vga_state_t;

    typedef struct packed {
        int h_active;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_active;
        int v_fp;
        int v_sync;
        int v_bp;
    } vga_timing_t;

    // 640x480@60, 25.175 MHz nominal (25 MHz in practice)
    localparam vga_timing_t VGA_640X480_60 = '{
        h_active: 640, h_fp: 16, h_sync: 96,  h_bp: 48,
        v_active: 480, v_fp: 10, v_sync: 2,   v_bp: 33
    };

    // 800x600@72, 50 MHz
    localparam vga_timing_t VGA_800X600_72 = '{
        h_active: 800, h_fp: 56, h_sync: 120, h_bp: 64,
        v_active: 600, v_fp: 37, v_sync: 6,   v_bp: 23
    };

    function automatic int h_total(input vga_timing_t t);
        return t.h_active + t.h_fp + t.h_sync + t.h_bp;
    endfunction

    function automatic int v_total(input vga_timing_t t);
        return t.v_active + t.v_fp + t.v_sync + t.v_bp;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth register delay line with a per-bit reset value; depth 0 is a wire.
module vga_delay_line #(
    parameter int             W       = 4,
    parameter int             DEPTH   = 2,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         vga_clk,
    input  logic         reset_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_clk_rst;
            assign unused_clk_rst = vga_clk ^ reset_n;
            assign dout = din;
        end else begin : g_pipe
            logic [DEPTH-1:0][W-1:0] stage;

            always_ff @(posedge vga_clk or negedge reset_n) begin
                if (!reset_n) begin
                    stage <= {DEPTH{RST_VAL}};
                end else begin
                    stage[0] <= din;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: run/stop FSM that only stops on a frame boundary,
// h/v counters, frame/line strobes and delayed sync/blank outputs.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   PIPE_DLY = 2,
    parameter int   CW       = 10
) (
    input  logic          vga_clk,
    input  logic          reset_n,
    input  logic          en,
    output logic          vga_hs,
    output logic          vga_vs,
    output logic          vga_blank_n,
    output logic          vga_sync_n,
    output logic [CW-1:0] hcount,
    output logic [CW-1:0] vcount,
    output logic          active,
    output logic          line_start,
    output logic          frame_start,
    output logic          running
);

    localparam vga_timing_t TIMING = '{
        h_active: H_ACTIVE, h_fp: H_FP, h_sync: H_SYNC, h_bp: H_BP,
        v_active: V_ACTIVE, v_fp: V_FP, v_sync: V_SYNC, v_bp: V_BP
    };
    localparam int H_TOTAL = h_total(TIMING);
    localparam int V_TOTAL = v_total(TIMING);

    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT_END  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_END  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] H_SYNC_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_SYNC_END = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_SYNC_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_SYNC_END = CW'(V_ACTIVE + V_FP + V_SYNC);

    // Bit order of the delayed bundle: {hs, vs, blank_n, sync_n}
    localparam logic [3:0] TIMING_IDLE = {~HS_POL, ~VS_POL, 1'b0, 1'b1};

    vga_state_t state, state_nxt;

    logic h_last, v_last, frame_last;
    logic h_sync_reg, v_sync_reg;
    logic [3:0] timing_raw, timing_dly;

    assign h_last     = (hcount == H_LAST);
    assign v_last     = (vcount == V_LAST);
    assign frame_last = h_last & v_last;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // A fresh run request while stopping wins over the frame-end exit, so a
    // late re-raise of en keeps the raster going instead of dropping a frame.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en) state_nxt = RUN;
            RUN:     if (!en) state_nxt = STOP;
            STOP: begin
                if (en)              state_nxt = RUN;
                else if (frame_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign running = (state != IDLE);

    // IDLE is only entered on the frame wrap, so the counters are already 0.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hcount <= '0;
            vcount <= '0;
        end else if (running) begin
            hcount <= h_last ? '0 : hcount + 1'b1;
            if (h_last) vcount <= v_last ? '0 : vcount + 1'b1;
        end
    end

    assign h_sync_reg = (hcount >= H_SYNC_BEG) && (hcount < H_SYNC_END);
    assign v_sync_reg = (vcount >= V_SYNC_BEG) && (vcount < V_SYNC_END);

    assign active      = (hcount < H_ACT_END) && (vcount < V_ACT_END) && running;
    assign line_start  = running && (hcount == '0);
    assign frame_start = line_start && (vcount == '0);

    always_comb begin
        timing_raw = TIMING_IDLE;
        if (running) begin
            timing_raw[3] = h_sync_reg ? HS_POL : ~HS_POL;
            timing_raw[2] = v_sync_reg ? VS_POL : ~VS_POL;
            timing_raw[1] = active;
            timing_raw[0] = ~(h_sync_reg | v_sync_reg);
        end
    end

    vga_delay_line #(
        .W       (4),
        .DEPTH   (PIPE_DLY),
        .RST_VAL (TIMING_IDLE)
    ) u_dly (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .din     (timing_raw),
        .dout    (timing_dly)
    );

    assign vga_hs      = timing_dly[3];
    assign vga_vs      = timing_dly[2];
    assign vga_blank_n = timing_dly[1];
    assign vga_sync_n  = timing_dly[0];

endmodule
